// File: rtl/accum_pkg.sv
// Shared definitions for the accumulator BCD display block.
// Holds the default binary width / decimal digit count, the converter FSM
// state encoding and the active-low seven-segment codes (bit order gfedcba).
// seg_encode() maps a BCD digit to its segment code; codes above 9 map to
// blank so a corrupted digit can never show a misleading glyph.
package accum_pkg;

    localparam int DEFAULT_WIDTH  = 8;
    localparam int DEFAULT_DIGITS = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] seg_encode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD to seven-segment decoder, one instance per display digit.
// Ports:
//   bcd_i   [3:0] BCD digit
//   blank_i       force all segments off
//   seg_o   [6:0] active-low segments gfedcba
module seg7_decoder
    import accum_pkg::*;
(
    input  logic [3:0] bcd_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    always_comb begin
        if (blank_i) seg_o = SEG_BLANK;
        else         seg_o = seg_encode(bcd_i);
    end

endmodule

// File: rtl/accum_bcd_display.sv
// Binary to decimal seven-segment display for an accumulator result.
// A load strobe in IDLE captures value; a double-dabble converter runs for
// WIDTH cycles (busy high), then one DONE cycle registers the decoded digits
// onto the HEX outputs and pulses done. HEX outputs only change at DONE.
// Ports:
//   CLOCK_50            clock, rising edge
//   RESET               synchronous active-high reset
//   value [WIDTH-1:0]   unsigned binary to display
//   load                conversion request, honoured only in IDLE
//   busy                conversion in progress
//   done                one-cycle pulse when new digits are shown
//   HEX0/HEX1/HEX2      active-low segments gfedcba, HEX0 = units
// Build option: define ACCUM_BCD_LEADING_BLANK_EN to blank leading zero
// digits (units digit always shown).
// The three HEX ports expect DIGITS >= 3.
module accum_bcd_display
    import accum_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int DIGITS = DEFAULT_DIGITS
) (
    input  logic             CLOCK_50,
    input  logic             RESET,
    input  logic [WIDTH-1:0] value,
    input  logic             load,
    output logic             busy,
    output logic             done,
    output logic [6:0]       HEX0,
    output logic [6:0]       HEX1,
    output logic [6:0]       HEX2
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int BW = DIGITS * 4;

`ifdef ACCUM_BCD_LEADING_BLANK_EN
    localparam logic [6:0] SEG_UPPER_RST = SEG_BLANK;
`else
    localparam logic [6:0] SEG_UPPER_RST = SEG_0;
`endif

    state_t                  state_q, state_d;
    logic [WIDTH-1:0]        sh_q, sh_d;
    logic [BW-1:0]           bcd_q, bcd_d, bcd_adj;
    logic [BW+WIDTH-1:0]     shifted;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [DIGITS-1:0][6:0]  hex_q, hex_d, seg_w;
    logic [DIGITS-1:0]       blank_w;
    logic                    done_q, done_d;

    // Digit decoders watch the BCD register; their outputs are only
    // captured in DONE, when the register holds the finished result.
    for (genvar g = 0; g < DIGITS; g++) begin : g_dec
        seg7_decoder u_dec (
            .bcd_i   (bcd_q[g*4 +: 4]),
            .blank_i (blank_w[g]),
            .seg_o   (seg_w[g])
        );
    end

    // Leading-zero suppression: scan from the top digit down, blanking
    // zeros until the first nonzero digit. Digit 0 is never blanked.
    always_comb begin
        blank_w = '0;
`ifdef ACCUM_BCD_LEADING_BLANK_EN
        begin
            logic lead;
            lead = 1'b1;
            for (int i = DIGITS - 1; i > 0; i--) begin
                if (lead && (bcd_q[i*4 +: 4] == 4'd0)) blank_w[i] = 1'b1;
                else                                  lead       = 1'b0;
            end
        end
`endif
    end

    // One double-dabble step: add 3 to digits >= 5 so the following shift
    // carries correctly into the next decimal digit.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
        end
        shifted = {bcd_adj, sh_q} << 1;
    end

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        hex_d   = hex_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (load) begin
                    sh_d    = value;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                {bcd_d, sh_d} = shifted;
                cnt_d         = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) state_d = DONE;
            end
            DONE: begin
                hex_d   = seg_w;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state_q <= IDLE;
            sh_q    <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            for (int i = 0; i < DIGITS; i++) begin
                hex_q[i] <= (i == 0) ? SEG_0 : SEG_UPPER_RST;
            end
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            hex_q   <= hex_d;
        end
    end

    assign busy = (state_q == SHIFT);
    assign done = done_q;
    assign HEX0 = hex_q[0];
    assign HEX1 = hex_q[1];
    assign HEX2 = hex_q[2];

endmodule

// File: tb/tb_accum_bcd_display.sv
// Self-checking bench for accum_bcd_display (WIDTH=8, DIGITS=3).
// Directed table, hand-written multi-cycle sequences and random values
// checked against a decimal-arithmetic reference model.
module tb_accum_bcd_display;

    localparam int WIDTH = 8;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] SB = 7'b1111111;
`ifdef ACCUM_BCD_LEADING_BLANK_EN
    localparam logic [6:0] LZ = SB;
`else
    localparam logic [6:0] LZ = S0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] value;
    logic             load;
    logic             busy, done;
    logic [6:0]       hex0, hex1, hex2;

    int checks = 0;
    int errors = 0;
    logic [20:0] cur_hex;

    accum_bcd_display #(.WIDTH(WIDTH), .DIGITS(3)) dut (
        .CLOCK_50 (clk),
        .RESET    (rst),
        .value    (value),
        .load     (load),
        .busy     (busy),
        .done     (done),
        .HEX0     (hex0),
        .HEX1     (hex1),
        .HEX2     (hex2)
    );

    always #10 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] dseg(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            default: return 7'b0010000;
        endcase
    endfunction

    // Reference: decimal digits by plain division, leading-blank rule applied on top.
    function automatic logic [20:0] model(input int v);
        int d0, d1, d2;
        logic [6:0] h0, h1, h2;
        d0 = v % 10;
        d1 = (v / 10) % 10;
        d2 = (v / 100) % 10;
        h0 = dseg(d0);
        h1 = dseg(d1);
        h2 = dseg(d2);
`ifdef ACCUM_BCD_LEADING_BLANK_EN
        if (d2 == 0) h2 = SB;
        if (d2 == 0 && d1 == 0) h1 = SB;
`endif
        return {h2, h1, h0};
    endfunction

    // One conversion; optionally pokes an extra load (value 99) poke_at
    // edges after the accepted one, which must be ignored.
    task automatic run_conv(input string name, input logic [7:0] v, input logic [20:0] exp, input int poke_at);
        int busy_n, done_n, done_at;
        logic hold_bad;
        busy_n = 0; done_n = 0; done_at = -1; hold_bad = 1'b0;
        value = v;
        load  = 1'b1;
        tick();
        load  = 1'b0;
        value = WIDTH'($urandom);
        for (int c = 0; c <= WIDTH + 3; c++) begin
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                if (done_at < 0) done_at = c;
            end
            if (done_at < 0 && {hex2, hex1, hex0} !== cur_hex) hold_bad = 1'b1;
            if (c == poke_at) begin
                load  = 1'b1;
                value = 8'd99;
            end else begin
                load  = 1'b0;
                value = WIDTH'($urandom);
            end
            tick();
        end
        load = 1'b0;
        check({name, " done latency"}, done_at, WIDTH + 1);
        check({name, " done pulses"}, done_n, 1);
        check({name, " busy cycles"}, busy_n, WIDTH);
        check({name, " hex held"}, hold_bad, 1'b0);
        check({name, " hex"}, {hex2, hex1, hex0}, exp);
        cur_hex = exp;
    endtask

    typedef struct {
        logic [7:0] v;
        logic [6:0] h2, h1, h0;
        int         poke;
    } vec_t;

    initial begin
        vec_t tbl[10];
        logic [20:0] rst_hex;
        int done_n, first_done, second_done, bad;

        tbl[0] = '{8'd127, S1, S2, S7, -1};
        tbl[1] = '{8'd255, S2, S5, S5, -1};
        tbl[2] = '{8'd0,   LZ, LZ, S0, -1};
        tbl[3] = '{8'd100, S1, S0, S0, -1};
        tbl[4] = '{8'd5,   LZ, LZ, S5, -1};
        tbl[5] = '{8'd42,  LZ, S4, S2, 3};
        tbl[6] = '{8'd99,  LZ, S9, S9, WIDTH};
        tbl[7] = '{8'd10,  LZ, S1, S0, 0};
        tbl[8] = '{8'd208, S2, S0, S8, -1};
        tbl[9] = '{8'd1,   LZ, LZ, S1, WIDTH - 1};

        rst_hex = {LZ, LZ, S0};

        // Reset state
        rst = 1'b1; load = 1'b0; value = '0;
        tick(); tick();
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        check("reset hex0", hex0, S0);
        check("reset hex1", hex1, LZ);
        check("reset hex2", hex2, LZ);
        rst = 1'b0;
        tick();
        cur_hex = rst_hex;

        // Directed table
        for (int i = 0; i < 10; i++) begin
            run_conv($sformatf("vec%0d", i), tbl[i].v, {tbl[i].h2, tbl[i].h1, tbl[i].h0}, tbl[i].poke);
        end

        // Reset in the middle of SHIFT, with load also high (reset wins)
        value = 8'd200; load = 1'b1;
        tick();
        load = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1; load = 1'b1;
        tick();
        check("abort busy", busy, 1'b0);
        check("abort hex", {hex2, hex1, hex0}, rst_hex);
        tick();
        rst = 1'b0; load = 1'b0;
        done_n = 0; bad = 0;
        for (int c = 0; c < 14; c++) begin
            if (done) done_n++;
            if (busy) bad++;
            tick();
        end
        check("abort no done", done_n, 0);
        check("abort idle", bad, 0);
        check("abort hex after", {hex2, hex1, hex0}, rst_hex);
        cur_hex = rst_hex;
        run_conv("after abort", 8'd7, model(7), -1);

        // load held high: a new conversion on every return to IDLE
        value = 8'd63; load = 1'b1;
        done_n = 0; first_done = -1; second_done = -1;
        for (int e = 1; e <= 3 * (WIDTH + 2); e++) begin
            tick();
            if (done) begin
                done_n++;
                if (first_done < 0) first_done = e;
                else if (second_done < 0) second_done = e;
            end
        end
        load = 1'b0;
        for (int c = 0; c < WIDTH + 4; c++) tick();
        check("held load dones", done_n, 3);
        check("held load first", first_done, WIDTH + 2);
        check("held load spacing", second_done - first_done, WIDTH + 2);
        check("held load hex", {hex2, hex1, hex0}, model(63));
        cur_hex = model(63);

        // Random values against the reference model
        for (int n = 0; n < 24; n++) begin
            int v, p;
            v = int'($urandom_range(0, 255));
            p = int'($urandom_range(0, WIDTH + 6));
            if (p > WIDTH) p = -1;
            run_conv($sformatf("rand%0d v=%0d", n, v), 8'(v), model(v), p);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/accum_bcd_display.md
ACCUM_BCD_DISPLAY -- requirements
Module: accum_bcd_display

Interface
REQ-001 SHALL have parameter WIDTH, default 8, binary input width (7-bit accumulator result plus carry).
REQ-002 SHALL have parameter DIGITS, default 3, number of decimal digits (ceil(WIDTH*log10(2))).
REQ-003 SHALL have CLOCK_50  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have RESET  input  1  synchronous, active-high reset, sampled on CLOCK_50 rising edge.
REQ-005 SHALL have value  input  WIDTH  unsigned binary to display ({carry, result}).
REQ-006 SHALL have load  input  1  request pulse to convert value (debounced button strobe).
REQ-007 SHALL have busy  output  1  high while a conversion is in progress.
REQ-008 SHALL have done  output  1  one-cycle pulse when new digits appear on HEX outputs.
REQ-009 SHALL have HEX0, HEX1, HEX2  output  7 each  active-low segments gfedcba; HEX0 = units.

Function
REQ-010 SHALL implement FSM states IDLE, SHIFT, DONE; only IDLE accepts load.
REQ-011 In IDLE with load=1 at edge k: SHALL latch value into shift register, clear BCD register, clear bit counter, enter SHIFT.
REQ-012 In SHIFT, each cycle SHALL add 3 to every BCD digit >= 5, then shift {BCD, shift register} left by one bit.
REQ-013 SHALL stay in SHIFT exactly WIDTH cycles (busy=1 at edges k+1..k+WIDTH), then enter DONE.
REQ-014 On entering DONE (edge k+WIDTH+1) SHALL register decoded digits onto HEX0..HEX2, assert done for exactly that cycle, deassert busy, return to IDLE next cycle.
REQ-015 Total latency load-to-done SHALL be WIDTH+1 cycles; minimum spacing between accepted loads SHALL be WIDTH+2 cycles.
REQ-016 load asserted in SHIFT or DONE SHALL be ignored (not queued); value changes after edge k SHALL not affect the result.
REQ-017 HEX outputs SHALL hold their last values until the next DONE; no intermediate values shall appear.
REQ-018 Input 2**WIDTH-1 (255) SHALL display 2,5,5; no overflow case exists for WIDTH=8, DIGITS=3.
REQ-019 Digit codes: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, blank=1111111.
REQ-020 load held high continuously SHALL start a new conversion on each return to IDLE.

Reset
REQ-021 RESET=1 SHALL force IDLE, busy=0, done=0, counter and BCD register cleared, HEX0=1000000 ("0").
REQ-022 HEX1, HEX2 reset value SHALL be 1000000 without the blanking macro, 1111111 with it.
REQ-023 RESET during SHIFT or DONE SHALL abort the conversion with no done pulse; RESET has priority over load in the same cycle.

Configuration
REQ-024 Macro ACCUM_BCD_LEADING_BLANK_EN defined: leading zero digits above the most significant nonzero digit SHALL show blank; HEX0 SHALL never blank; interior zeros SHALL show "0".
REQ-025 Macro not defined: all DIGITS digits SHALL always show decoded values including leading zeros.

Structure
REQ-026 Shared package accum_pkg SHALL hold the FSM state enum, segment code constants (SEG_0..SEG_9, SEG_BLANK) and the default WIDTH/DIGITS.
REQ-027 A sub-module seg7_decoder (4-bit BCD plus blank flag in, 7-bit active-low out, combinational) SHALL be instantiated once per digit.

Verification
REQ-028 RESET 2 cycles -> busy=0, done=0, HEX0=1000000, HEX1/HEX2 per REQ-022.
REQ-029 value=127, load 1 cycle -> done exactly 9 cycles later, HEX2=1111001, HEX1=0100100, HEX0=1111000; busy high 8 cycles.
REQ-030 value=255 then value=0 (second load after done) -> "255" then "000", or blank,blank,"0" with macro.
REQ-031 value=100 with macro -> HEX2=1111001, HEX1=1000000, HEX0=1000000 (interior zeros kept); value=5 -> HEX2/HEX1=1111111, HEX0=0010010.
REQ-032 value=42 load, second load with value=99 three cycles later -> second ignored, display "42", single done pulse.
REQ-033 value=200 load, RESET asserted at cycle 4 of SHIFT -> no done pulse, reset values per REQ-021; next load value=7 -> correct "7".
